// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared op codes, FSM state encodings and small op-class helpers for the
// execute-stage mul/div sequencing controller and the decoder that feeds it.
package ex_muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MDST_IDLE  = 2'd0,
    MDST_ISSUE = 2'd1,
    MDST_WAIT  = 2'd2,
    MDST_HOLD  = 2'd3
  } mdst_e;

  localparam logic [2:0] MDOP_MUL    = 3'd0;
  localparam logic [2:0] MDOP_MULH   = 3'd1;
  localparam logic [2:0] MDOP_MULHSU = 3'd2;
  localparam logic [2:0] MDOP_MULHU  = 3'd3;
  localparam logic [2:0] MDOP_DIV    = 3'd4;
  localparam logic [2:0] MDOP_DIVU   = 3'd5;
  localparam logic [2:0] MDOP_REM    = 3'd6;
  localparam logic [2:0] MDOP_REMU   = 3'd7;

  // All divide-class ops share the top op bit.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // MUL and DIV/DIVU return the low half; every other op the high half.
  function automatic logic op_takes_high(input logic [2:0] op);
    return !((op == MDOP_MUL) || (op == MDOP_DIV) || (op == MDOP_DIVU));
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Combinational op decode for the mul/div controller: sign controls, result-half
// select and, when MD_DIV_FASTPATH_EN is defined, divide special-case detection.
module muldiv_fixup
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        dec_op,
`ifdef MD_DIV_FASTPATH_EN
  input  logic [XLEN-1:0]   dec_a,
  input  logic [XLEN-1:0]   dec_b,
  output logic              fast_hit,
  output logic [XLEN-1:0]   fast_data,
`endif
  input  logic [2:0]        sel_op,
  input  logic [2*XLEN-1:0] result,
  output logic              dec_div,
  output logic              dec_sign0,
  output logic              dec_sign1,
  output logic [XLEN-1:0]   sel_data
);

  always_comb begin
    dec_div   = op_is_div(dec_op);
    dec_sign0 = 1'b0;
    dec_sign1 = 1'b0;
    unique case (dec_op)
      MDOP_MUL, MDOP_MULH, MDOP_DIV, MDOP_REM: begin
        dec_sign0 = 1'b1;
        dec_sign1 = 1'b1;
      end
      MDOP_MULHSU: dec_sign0 = 1'b1;
      default: ;
    endcase
  end

  assign sel_data = op_takes_high(sel_op) ? result[2*XLEN-1:XLEN] : result[XLEN-1:0];

`ifdef MD_DIV_FASTPATH_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic div_zero;
  logic div_ovf;

  always_comb begin
    div_zero  = op_is_div(dec_op) && (dec_b == '0);
    // Signed overflow only exists for DIV/REM (even op codes of the divide class).
    div_ovf   = op_is_div(dec_op) && !dec_op[0] && (dec_a == MOST_NEG) && (dec_b == '1);
    fast_hit  = div_zero || div_ovf;
    fast_data = '0;
    if (div_zero) begin
      fast_data = op_takes_high(dec_op) ? dec_a : '1;
    end else if (div_ovf) begin
      fast_data = op_takes_high(dec_op) ? '0 : MOST_NEG;
    end
  end
`endif

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Sequencing controller between the execute stage and the shared iterative
// mul/div unit. Optional divide fast path is enabled by MD_DIV_FASTPATH_EN.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MAX_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  input  logic              req_kill,
  input  logic              resp_ready,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              ex_md_stall,
  output logic              unit_go,
  output logic              unit_div,
  output logic              unit_sign0,
  output logic              unit_sign1,
  output logic [XLEN-1:0]   unit_m,
  output logic [XLEN-1:0]   unit_r,
  output logic              unit_abort,
  input  logic              unit_done,
  input  logic [2*XLEN-1:0] unit_result,
  output logic              err_timeout,
  output mdst_e             fsm_state
);

  // Handshake: the request is held with req_valid until the response is taken;
  // the response transfers on a cycle with resp_valid & resp_ready.

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CYCLES);

  mdst_e           state;
  logic [2:0]      op_q;
  logic [CW-1:0]   cnt;
  logic            dec_div;
  logic            dec_sign0;
  logic            dec_sign1;
  logic [XLEN-1:0] sel_data;
  logic            in_flight;
  logic            timeout;
`ifdef MD_DIV_FASTPATH_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_data;
`endif

  muldiv_fixup #(.XLEN(XLEN)) u_fixup (
    .dec_op    (req_op),
`ifdef MD_DIV_FASTPATH_EN
    .dec_a     (req_a),
    .dec_b     (req_b),
    .fast_hit  (fast_hit),
    .fast_data (fast_data),
`endif
    .sel_op    (op_q),
    .result    (unit_result),
    .dec_div   (dec_div),
    .dec_sign0 (dec_sign0),
    .dec_sign1 (dec_sign1),
    .sel_data  (sel_data)
  );

  assign in_flight   = (state == MDST_ISSUE) || (state == MDST_WAIT);
  assign timeout     = (state == MDST_WAIT) && !unit_done && (cnt == CNT_MAX);
  assign unit_go     = (state == MDST_ISSUE);
  // The unit has its own reset, so no abort is sent while reset is high.
  assign unit_abort  = !reset && ((in_flight && req_kill) || timeout);
  assign resp_valid  = (state == MDST_HOLD) && !req_kill;
  assign ex_md_stall = req_valid && !(resp_valid && resp_ready);
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= MDST_IDLE;
      op_q        <= '0;
      cnt         <= '0;
      resp_data   <= '0;
      unit_m      <= '0;
      unit_r      <= '0;
      unit_div    <= 1'b0;
      unit_sign0  <= 1'b0;
      unit_sign1  <= 1'b0;
      err_timeout <= 1'b0;
    end else if (req_kill) begin
      state <= MDST_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        MDST_IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            unit_m     <= req_a;
            unit_r     <= req_b;
            unit_div   <= dec_div;
            unit_sign0 <= dec_sign0;
            unit_sign1 <= dec_sign1;
            cnt        <= '0;
`ifdef MD_DIV_FASTPATH_EN
            if (fast_hit) begin
              resp_data <= fast_data;
              state     <= MDST_HOLD;
            end else begin
              state <= MDST_ISSUE;
            end
`else
            state <= MDST_ISSUE;
`endif
          end
        end
        MDST_ISSUE: begin
          if (unit_done) begin
            resp_data <= sel_data;
            state     <= MDST_HOLD;
          end else begin
            cnt   <= CW'(1);
            state <= MDST_WAIT;
          end
        end
        MDST_WAIT: begin
          if (unit_done) begin
            resp_data <= sel_data;
            state     <= MDST_HOLD;
          end else if (cnt == CNT_MAX) begin
            resp_data   <= '0;
            err_timeout <= 1'b1;
            state       <= MDST_HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        MDST_HOLD: begin
          if (resp_ready) state <= MDST_IDLE;
        end
      endcase
    end
  end

endmodule
